cache_array: RTL and testbench
==============================

# cache_array

Parametrised, clocked successor to the L1 cache storage array: a set-associative line store (tag, LRU, MESI, data per way) with a valid/ready request port, a registered whole-set read, per-way masked writes, and a multi-cycle clear sweep that runs automatically after reset. It sits between the cache controller (LRU/MESI policy) and the trace-driven top level. The controller reads a set, computes the updated lines, and writes them back.

## Interface
- SETS, 16384: number of sets, power of two, ≥2; SET_W = $clog2(SETS)
- WAYS, 8: ways per set, power of two, ≥2; LRU_W = $clog2(WAYS)
- TAG_W, 12: tag width
- DATA_W, 32: data field width per line
- Derived: LINE_W = TAG_W+LRU_W+2+DATA_W. Line packing MSB→LSB is {tag, LRU, MESI, data}. MESI encoding is I=0, S=1, E=2, M=3 (package enum). Way w occupies bits [w*LINE_W +: LINE_W].
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at rising edge
- req_op  in  2  00 READ, 01 WRITE, 10 CLEAR, 11 NOP
- req_set  in  SET_W  set index
- req_tag  in  TAG_W  lookup tag (used only with CACHE_ARRAY_LOOKUP_EN)
- wr_way_mask  in  WAYS  ways written on WRITE
- wr_lines  in  WAYS*LINE_W  write data for all ways
- rd_valid  out  1  one-cycle pulse, rd_lines valid
- rd_lines  out  WAYS*LINE_W  registered contents of the read set
- busy  out  1  clear sweep in progress
- hit  out  1  lookup hit (macro only)
- hit_way  out  LRU_W  hitting way (macro only)

## Operation
- FSM states are SWEEP and IDLE. Asserting rst_n low forces SWEEP with sweep counter = 0.
- SWEEP: each cycle writes set[cnt] for all ways w with LRU=w, MESI=I, tag=0, data=0. Then cnt increments. After set SETS-1 is written, the FSM goes to IDLE. In SWEEP, req_ready=0 and busy=1.
- IDLE: req_ready=1 and busy=0. Handling of accepted requests:
  - READ: all ways of req_set are registered into rd_lines, and rd_valid pulses the next cycle.
  - WRITE: for each w with wr_way_mask[w]=1, way w of req_set takes the corresponding slice of wr_lines. Ways with a clear mask bit are unchanged. A mask of 0 is a legal no-op. No rd_valid.
  - CLEAR: cnt=0, go to SWEEP.
  - NOP: accepted, no effect, no rd_valid.
- rd_lines holds its value until the next READ completes.
- The block performs no LRU or MESI policy. Stored values are whatever the controller writes.

## Timing
- Reset values:
  - req_ready=0, busy=1, rd_valid=0.
  - rd_lines=0.
  - hit=0, hit_way=0.
  - FSM=SWEEP, cnt=0.
- After rst_n rises, sets 0..SETS-1 are written on edges 1..SETS. req_ready goes to 1 after edge SETS, so the first request can be accepted on edge SETS+1.
- CLEAR accepted on edge T: sets are written on edges T+1..T+SETS. req_ready=1 again after edge T+SETS.
- READ latency is 1 cycle. A READ accepted on edge T gives rd_valid=1 between edges T and T+1.
- WRITE on edge T followed by READ of the same set on edge T+1 returns the written data. There is no stale-read window.
- Back-to-back requests are sustained at one per cycle in IDLE.
- Reset asserted mid-sweep or mid-read restarts the sweep from set 0. A pending rd_valid is dropped.
- Sweep counter arithmetic is SET_W+1 bits, so there is no wrap ambiguity at SETS-1.

## Configuration
- CACHE_ARRAY_LOOKUP_EN defined:
  - A READ also registers hit and hit_way together with rd_lines.
  - hit=1 iff some way has tag==req_tag and MESI≠I.
  - hit_way is the lowest such way index, and 0 on a miss.
- CACHE_ARRAY_LOOKUP_EN undefined: hit and hit_way are tied to 0, and req_tag is ignored.

## Test plan
Bench configuration is SETS=16, WAYS=4, TAG_W=12, DATA_W=32.
- Reset release: req_ready=0 and busy=1 for 16 cycles. Then a READ of set 5 returns LRU={0,1,2,3}, MESI=I, tag=0, data=0.
- WRITE set 3, mask 4'b0100, way2={tag 0xABC, LRU 1, M, 0xDEADBEEF}, then READ set 3 next cycle: rd_valid one cycle later, way2 matches, ways 0/1/3 still at cleared values.
- Back-to-back WRITE set 7, READ set 7, READ set 8: two rd_valid pulses on consecutive cycles with correct data. req_ready stays high.
- CLEAR after dirtying sets 0 and 15: req_ready low for exactly 16 cycles, then both sets read back as cleared. A request held valid during the sweep is not accepted until ready returns.
- rst_n pulsed low at sweep cycle 9: outputs return to reset values immediately, and the sweep restarts and lasts a full 16 cycles.
- With CACHE_ARRAY_LOOKUP_EN: way1 tag 0x123 in state S and way3 tag 0x123 in state E; READ with req_tag 0x123 gives hit=1, hit_way=1. Invalidate way1 and read again: hit_way=3. READ with req_tag 0x456 gives hit=0.

Source files
------------

// File: rtl/cache_array_if.sv
// cache_array_pkg / cache_array_if
//
// Package: shared encodings for the cache line store (MESI states, request
// opcodes, array FSM states).
//
// Interface: request/response bundle between the cache controller (master)
// and the line store (slave).
//   req_valid   m->s  request present
//   req_ready   s->m  store can accept a request this cycle
//   req_op      m->s  00 READ, 01 WRITE, 10 CLEAR, 11 NOP
//   req_set     m->s  set index
//   req_tag     m->s  lookup tag (only used when CACHE_ARRAY_LOOKUP_EN is set)
//   wr_way_mask m->s  ways written on WRITE
//   wr_lines    m->s  write data for all ways, way w at [w*LINE_W +: LINE_W]
//   rd_valid    s->m  one-cycle pulse, rd_lines holds a freshly read set
//   rd_lines    s->m  registered contents of the last read set
//   busy        s->m  clear sweep in progress
//   hit/hit_way s->m  lookup result registered with rd_lines
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. The master keeps req_* stable while req_valid is high
// and req_ready is low; req_ready does not depend on req_valid.

package cache_array_pkg;
  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;
endpackage

interface cache_array_if #(
  parameter int SETS   = 16384,
  parameter int WAYS   = 8,
  parameter int TAG_W  = 12,
  parameter int DATA_W = 32
);
  localparam int SET_W  = $clog2(SETS);
  localparam int LRU_W  = $clog2(WAYS);
  localparam int LINE_W = TAG_W + LRU_W + 2 + DATA_W;

  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [SET_W-1:0]       req_set;
  logic [TAG_W-1:0]       req_tag;
  logic [WAYS-1:0]        wr_way_mask;
  logic [WAYS*LINE_W-1:0] wr_lines;
  logic                   rd_valid;
  logic [WAYS*LINE_W-1:0] rd_lines;
  logic                   busy;
  logic                   hit;
  logic [LRU_W-1:0]       hit_way;

  modport master (
    output req_valid, req_op, req_set, req_tag, wr_way_mask, wr_lines,
    input  req_ready, rd_valid, rd_lines, busy, hit, hit_way
  );

  modport slave (
    input  req_valid, req_op, req_set, req_tag, wr_way_mask, wr_lines,
    output req_ready, rd_valid, rd_lines, busy, hit, hit_way
  );
endinterface

// File: rtl/cache_array.sv
// cache_array
//
// Set-associative line store: per set, WAYS lines packed {tag, LRU, MESI,
// data}. Serves whole-set registered reads, per-way masked writes and a
// multi-cycle clear sweep that also runs automatically after reset. No LRU or
// MESI policy lives here; the controller owns all line contents.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (forces a fresh clear sweep)
//   bus      cache_array_if.slave request/response bundle
//   state_o  current FSM state (debug visibility)
//
// Optional feature: define CACHE_ARRAY_LOOKUP_EN to register a tag lookup
// (hit/hit_way) alongside every READ. Without it hit/hit_way are 0 and
// req_tag is ignored.

module cache_array
  import cache_array_pkg::*;
#(
  parameter int SETS   = 16384,
  parameter int WAYS   = 8,
  parameter int TAG_W  = 12,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  cache_array_if.slave  bus,
  output state_e        state_o
);
  localparam int SET_W  = $clog2(SETS);
  localparam int LRU_W  = $clog2(WAYS);
  localparam int LINE_W = TAG_W + LRU_W + 2 + DATA_W;
  localparam int SET_BITS = WAYS * LINE_W;
  // Field offsets inside one line.
  localparam int MESI_LSB = DATA_W;
  localparam int LRU_LSB  = DATA_W + 2;
  localparam int TAG_LSB  = DATA_W + 2 + LRU_W;
  // Counter is one bit wider than the set index so the last set compares
  // cleanly without wrapping.
  localparam logic [SET_W:0] LAST_SET = (SET_W+1)'(SETS - 1);

  state_e               state_q, state_d;
  logic [SET_W:0]       cnt_q, cnt_d;
  logic                 ready;
  logic                 busy;
  logic                 sweep_we;
  logic                 accept;
  logic                 rd_op;
  logic                 wr_op;

  logic [SET_BITS-1:0]  mem_q [SETS];
  logic [SET_BITS-1:0]  clear_set;
  logic [SET_BITS-1:0]  rd_lines_q;
  logic                 rd_valid_q;

  // Cleared set: every field zero except LRU, which takes the way index.
  always_comb begin
    clear_set = '0;
    for (int w = 0; w < WAYS; w++) begin
      clear_set[w*LINE_W + LRU_LSB +: LRU_W] = LRU_W'(w);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state and outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    busy     = 1'b0;
    sweep_we = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        busy     = 1'b1;
        sweep_we = 1'b1;
        if (cnt_q == LAST_SET) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.req_valid && bus.req_op == OP_CLEAR) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  assign accept = bus.req_valid && ready;
  assign rd_op  = accept && (bus.req_op == OP_READ);
  assign wr_op  = accept && (bus.req_op == OP_WRITE);

  // Line storage. Not reset: the sweep that follows reset initialises it.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[cnt_q[SET_W-1:0]] <= clear_set;
    end else if (wr_op) begin
      for (int w = 0; w < WAYS; w++) begin
        if (bus.wr_way_mask[w]) begin
          mem_q[bus.req_set][w*LINE_W +: LINE_W] <= bus.wr_lines[w*LINE_W +: LINE_W];
        end
      end
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_lines_q <= '0;
    end else begin
      rd_valid_q <= rd_op;
      if (rd_op) begin
        rd_lines_q <= mem_q[bus.req_set];
      end
    end
  end

`ifdef CACHE_ARRAY_LOOKUP_EN
  logic [SET_BITS-1:0] lk_set;
  logic                lk_hit;
  logic [LRU_W-1:0]    lk_way;
  logic                hit_q;
  logic [LRU_W-1:0]    hit_way_q;

  // Scan from the top way down so the lowest matching way wins.
  always_comb begin
    lk_set = mem_q[bus.req_set];
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_set[w*LINE_W + TAG_LSB +: TAG_W] == bus.req_tag &&
          lk_set[w*LINE_W + MESI_LSB +: 2] != MESI_I) begin
        lk_hit = 1'b1;
        lk_way = LRU_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q     <= 1'b0;
      hit_way_q <= '0;
    end else if (rd_op) begin
      hit_q     <= lk_hit;
      hit_way_q <= lk_way;
    end
  end

  assign bus.hit     = hit_q;
  assign bus.hit_way = hit_way_q;
`else
  logic unused_req_tag;
  assign unused_req_tag = ^bus.req_tag;
  assign bus.hit        = 1'b0;
  assign bus.hit_way    = '0;
`endif

  assign bus.req_ready = ready;
  assign bus.busy      = busy;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_lines  = rd_lines_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_cache_array.sv
// tb_cache_array: directed bench for cache_array with SETS=16, WAYS=4,
// TAG_W=12, DATA_W=32 (LINE_W=48, 192-bit sets).

module tb_cache_array;
  import cache_array_pkg::*;

  localparam int SETS   = 16;
  localparam int WAYS   = 4;
  localparam int TAG_W  = 12;
  localparam int DATA_W = 32;
  localparam int LINE_W = 48;
  localparam int SB     = WAYS * LINE_W;

  logic   clk;
  logic   rst_n;
  state_e state;
  int     compared;
  int     mismatched;
  int     low_cnt;
  logic   busy_ok;
  logic   early_acc;
  logic [SB-1:0] cleared;
  logic [SB-1:0] exp_set;
  logic [SB-1:0] lines_a;

  cache_array_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cache_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Helpers
  function automatic logic [LINE_W-1:0] mk_line(input logic [11:0] tag, input logic [1:0] lru,
                                                input logic [1:0] mesi, input logic [31:0] data);
    return {tag, lru, mesi, data};
  endfunction

  task automatic check(input string tag, input logic [SB-1:0] obs, input logic [SB-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] set, input logic [11:0] tag,
                       input logic [3:0] mask, input logic [SB-1:0] lines);
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_set     = set;
    bus.req_tag     = tag;
    bus.wr_way_mask = mask;
    bus.wr_lines    = lines;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
  endtask

  // Counts samples with req_ready low (starting at the current sample) until
  // ready returns, bounded.
  task automatic wait_sweep(input string tag);
    low_cnt = 0;
    busy_ok = 1'b1;
    early_acc = 1'b0;
    while (!bus.req_ready && low_cnt < 100) begin
      low_cnt++;
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      if (bus.rd_valid) early_acc = 1'b1;
    end
    check({tag, "_low_cycles"}, SB'(low_cnt), SB'(16));
    check({tag, "_busy_high"}, SB'(busy_ok), SB'(1));
    check({tag, "_busy_after"}, SB'(bus.busy), SB'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, SB'(bus.req_ready), SB'(0));
    check({tag, "_busy"}, SB'(bus.busy), SB'(1));
    check({tag, "_rd_valid"}, SB'(bus.rd_valid), SB'(0));
    check({tag, "_rd_lines"}, bus.rd_lines, '0);
    check({tag, "_hit"}, SB'(bus.hit), SB'(0));
    check({tag, "_hit_way"}, SB'(bus.hit_way), SB'(0));
    check({tag, "_state"}, SB'(state), SB'(ST_SWEEP));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cleared    = '0;
    for (int w = 0; w < WAYS; w++) cleared[w*LINE_W +: LINE_W] = mk_line(12'h0, 2'(w), 2'd0, 32'h0);

    rst_n = 1'b0;
    idle();
    bus.req_set = '0; bus.req_tag = '0; bus.wr_way_mask = '0; bus.wr_lines = '0;

    // Reset state and power-up sweep
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep("init_sweep");

    // READ set 5 after sweep
    drive(OP_READ, 4'd5, 12'h0, 4'h0, '0);
    idle();
    check("rd5_valid", SB'(bus.rd_valid), SB'(1));
    check("rd5_lines", bus.rd_lines, cleared);
    @(posedge clk); #1;
    check("rd5_pulse_end", SB'(bus.rd_valid), SB'(0));
    check("rd5_hold", bus.rd_lines, cleared);

    // Masked WRITE set 3 way 2, then READ next cycle
    lines_a = {SB{1'b1}};
    lines_a[2*LINE_W +: LINE_W] = mk_line(12'hABC, 2'd1, 2'd3, 32'hDEADBEEF);
    exp_set = cleared;
    exp_set[2*LINE_W +: LINE_W] = mk_line(12'hABC, 2'd1, 2'd3, 32'hDEADBEEF);
    drive(OP_WRITE, 4'd3, 12'h0, 4'b0100, lines_a);
    check("wr3_no_rd_valid", SB'(bus.rd_valid), SB'(0));
    drive(OP_READ, 4'd3, 12'h0, 4'h0, '0);
    check("rd3_valid", SB'(bus.rd_valid), SB'(1));
    check("rd3_lines", bus.rd_lines, exp_set);

    // Mask 0 WRITE is a no-op
    drive(OP_WRITE, 4'd3, 12'h0, 4'b0000, {SB{1'b1}});
    drive(OP_READ, 4'd3, 12'h0, 4'h0, '0);
    idle();
    check("rd3_mask0_lines", bus.rd_lines, exp_set);

    // Back-to-back WRITE 7, READ 7, READ 8
    for (int w = 0; w < WAYS; w++)
      lines_a[w*LINE_W +: LINE_W] = mk_line(12'h700 + 12'(w), 2'(3 - w), 2'(w), 32'h1234_5670 + 32'(w));
    drive(OP_WRITE, 4'd7, 12'h0, 4'b1111, lines_a);
    drive(OP_READ, 4'd7, 12'h0, 4'h0, '0);
    check("b2b_rd7_valid", SB'(bus.rd_valid), SB'(1));
    check("b2b_rd7_lines", bus.rd_lines, lines_a);
    check("b2b_ready", SB'(bus.req_ready), SB'(1));
    drive(OP_READ, 4'd8, 12'h0, 4'h0, '0);
    check("b2b_rd8_valid", SB'(bus.rd_valid), SB'(1));
    check("b2b_rd8_lines", bus.rd_lines, cleared);
    drive(OP_NOP, 4'd7, 12'h0, 4'hF, '0);
    idle();
    check("nop_no_rd_valid", SB'(bus.rd_valid), SB'(0));
    check("nop_hold", bus.rd_lines, cleared);
    drive(OP_READ, 4'd7, 12'h0, 4'h0, '0);
    idle();
    check("nop_no_write", bus.rd_lines, lines_a);

    // CLEAR after dirtying sets 0 and 15; READ held during sweep
    drive(OP_WRITE, 4'd0, 12'h0, 4'b1111, {SB{1'b1}});
    drive(OP_WRITE, 4'd15, 12'h0, 4'b1111, lines_a);
    drive(OP_CLEAR, 4'd0, 12'h0, 4'h0, '0);
    bus.req_op = OP_READ;
    bus.req_set = 4'd0;
    wait_sweep("clear");
    check("clear_no_early_accept", SB'(early_acc), SB'(0));
    @(posedge clk); #1;
    check("clear_held_rd_valid", SB'(bus.rd_valid), SB'(1));
    check("clear_set0", bus.rd_lines, cleared);
    drive(OP_READ, 4'd15, 12'h0, 4'h0, '0);
    idle();
    check("clear_set15", bus.rd_lines, cleared);

    // Reset at sweep cycle 9
    drive(OP_WRITE, 4'd12, 12'h0, 4'b1111, lines_a);
    drive(OP_CLEAR, 4'd0, 12'h0, 4'h0, '0);
    idle();
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midsweep_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep("restart_sweep");
    drive(OP_READ, 4'd12, 12'h0, 4'h0, '0);
    idle();
    check("restart_set12", bus.rd_lines, cleared);

    // Reset while rd_valid is pending
    drive(OP_READ, 4'd7, 12'h0, 4'h0, '0);
    idle();
    check("midread_valid", SB'(bus.rd_valid), SB'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midread_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep("midread_sweep");

    // Lookup
    lines_a = '0;
    lines_a[1*LINE_W +: LINE_W] = mk_line(12'h123, 2'd1, 2'd1, 32'h11111111);
    lines_a[3*LINE_W +: LINE_W] = mk_line(12'h123, 2'd3, 2'd2, 32'h33333333);
    drive(OP_WRITE, 4'd2, 12'h0, 4'b1010, lines_a);
    drive(OP_READ, 4'd2, 12'h123, 4'h0, '0);
`ifdef CACHE_ARRAY_LOOKUP_EN
    check("lk1_hit", SB'(bus.hit), SB'(1));
    check("lk1_way", SB'(bus.hit_way), SB'(1));
    lines_a[1*LINE_W +: LINE_W] = mk_line(12'h123, 2'd1, 2'd0, 32'h11111111);
    drive(OP_WRITE, 4'd2, 12'h0, 4'b0010, lines_a);
    drive(OP_READ, 4'd2, 12'h123, 4'h0, '0);
    check("lk2_hit", SB'(bus.hit), SB'(1));
    check("lk2_way", SB'(bus.hit_way), SB'(3));
    drive(OP_READ, 4'd2, 12'h456, 4'h0, '0);
    check("lk3_hit", SB'(bus.hit), SB'(0));
    check("lk3_way", SB'(bus.hit_way), SB'(0));
`else
    check("nolk_hit", SB'(bus.hit), SB'(0));
    check("nolk_way", SB'(bus.hit_way), SB'(0));
`endif
    idle();
    exp_set = cleared;
    exp_set[1*LINE_W +: LINE_W] = lines_a[1*LINE_W +: LINE_W];
    exp_set[3*LINE_W +: LINE_W] = lines_a[3*LINE_W +: LINE_W];
    check("lk_set2_lines", bus.rd_lines, exp_set);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
